// File: rtl/sd_sector_rx_if.sv
// Bundle between the SD controller and the sector receiver: the
// controller side requests a block and feeds DAT samples, the receiver
// side writes the sector buffer and reports completion status.
interface sd_sector_rx_if #(
  parameter int AW = 9
);
  logic          start;
  logic          dat_stb;
  logic [3:0]    dat_in;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          buf_we;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic          timeout;

  // Controller / sample source side
  modport master (
    output start, dat_stb, dat_in,
    input  buf_addr, buf_data, buf_we, busy, done, crc_ok, timeout
  );

  // Receiver side
  modport slave (
    input  start, dat_stb, dat_in,
    output buf_addr, buf_data, buf_we, busy, done, crc_ok, timeout
  );
endinterface

// File: rtl/sd_sector_rx.sv
// SD 4-bit DAT block receiver. Waits for the start bit, assembles
// nibbles into bytes and writes them into the sector buffer, runs one
// CRC16-CCITT per DAT line, compares them against the received CRC
// field, checks the end bit and reports done with crc_ok / timeout.
module sd_sector_rx #(
  parameter int BYTES   = 512,
  parameter int AW      = 9,
  parameter int TIMEOUT = 65535
) (
  input logic           clk,
  input logic           reset,
  sd_sector_rx_if.slave sdIf
);

  // Timeout counter only has to hold TIMEOUT-1
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   NIB_LAST  = (AW + 1)'(2 * BYTES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_CRC,
    S_STOP,
    S_FIN
  } state_t;

  state_t        state_q;
  logic [AW:0]   nibCnt_q;
  logic [3:0]    bitCnt_q;
  logic [TW-1:0] toutCnt_q;
  logic [3:0]    hiNib_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic          crcOk_q;
  logic          tout_q;
  logic [15:0]   crc_q   [4];
  logic [15:0]   rxCrc_q [4];
  logic [15:0]   crc_d   [4];
  logic          crcMatch_d;

  // Next value of each per-line CRC when the current DAT bit is shifted in
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      crc_d[i] = {crc_q[i][14:0], 1'b0} ^
                 ((crc_q[i][15] ^ sdIf.dat_in[i]) ? 16'h1021 : 16'h0000);
    end
  end

  // All four computed CRCs agree with the CRC field received on the bus
  always_comb begin
    crcMatch_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (crc_q[i] != rxCrc_q[i]) crcMatch_d = 1'b0;
    end
  end

  // Receive state machine with registered buffer-write and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      nibCnt_q  <= '0;
      bitCnt_q  <= '0;
      toutCnt_q <= '0;
      hiNib_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crcOk_q   <= 1'b0;
      tout_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        crc_q[i]   <= '0;
        rxCrc_q[i] <= '0;
      end
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;

      // The address moves on once the write cycle is over, so it is stable
      // while buf_we is high; the last byte leaves it parked at BYTES-1.
      if (we_q && (addr_q != ADDR_LAST)) addr_q <= addr_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (sdIf.start) begin
            state_q   <= S_WAIT;
            busy_q    <= 1'b1;
            crcOk_q   <= 1'b0;
            tout_q    <= 1'b0;
            nibCnt_q  <= '0;
            bitCnt_q  <= '0;
            toutCnt_q <= '0;
            addr_q    <= '0;
            for (int i = 0; i < 4; i++) begin
              crc_q[i]   <= '0;
              rxCrc_q[i] <= '0;
            end
          end
        end

        S_WAIT: begin
          if (sdIf.dat_stb) begin
            if (sdIf.dat_in == 4'b0000) begin
              state_q <= S_DATA;
            end else if (toutCnt_q == TOUT_LAST) begin
              state_q <= S_FIN;
              tout_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              toutCnt_q <= toutCnt_q + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (sdIf.dat_stb) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= crc_d[i];
            if (!nibCnt_q[0]) begin
              hiNib_q <= sdIf.dat_in;
            end else begin
              data_q <= {hiNib_q, sdIf.dat_in};
              we_q   <= 1'b1;
            end
            nibCnt_q <= nibCnt_q + 1'b1;
            if (nibCnt_q == NIB_LAST) begin
              state_q  <= S_CRC;
              bitCnt_q <= '0;
            end
          end
        end

        S_CRC: begin
          if (sdIf.dat_stb) begin
            for (int i = 0; i < 4; i++) begin
              rxCrc_q[i] <= {rxCrc_q[i][14:0], sdIf.dat_in[i]};
            end
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 4'd15) state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (sdIf.dat_stb) begin
            crcOk_q <= (sdIf.dat_in == 4'b1111) && crcMatch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sdIf.buf_addr = addr_q;
  assign sdIf.buf_data = data_q;
  assign sdIf.buf_we   = we_q;
  assign sdIf.busy     = busy_q;
  assign sdIf.done     = done_q;
  assign sdIf.crc_ok   = crcOk_q;
  assign sdIf.timeout  = tout_q;

endmodule

// File: tb/tb_sd_sector_rx.sv
// Directed bench for sd_sector_rx: nominal, incrementing, bad CRC, bad
// end bit, partial start bit, timeout (second instance, TIMEOUT=8) and
// reset in the middle of a block.
module tb_sd_sector_rx;

  logic clk = 1'b0;
  logic reset;

  // 100 MHz system clock
  always #5 clk = ~clk;

  sd_sector_rx_if #(.AW(9)) sdIf ();
  sd_sector_rx_if #(.AW(9)) toIf ();

  sd_sector_rx #(.BYTES(512), .AW(9), .TIMEOUT(65535)) dut (
    .clk   (clk),
    .reset (reset),
    .sdIf  (sdIf.slave)
  );

  sd_sector_rx #(.BYTES(512), .AW(9), .TIMEOUT(8)) dutTo (
    .clk   (clk),
    .reset (reset),
    .sdIf  (toIf.slave)
  );

  // The short-timeout instance sees the same stimulus as the main one
  assign toIf.start   = sdIf.start;
  assign toIf.dat_stb = sdIf.dat_stb;
  assign toIf.dat_in  = sdIf.dat_in;

  int checkCount = 0;
  int passCount  = 0;
  int gapCycles  = 1;
  logic [7:0] expByte [512];

  int   writeCount = 0;
  int   addrErr    = 0;
  int   dataErr    = 0;
  int   expAddr    = 0;
  int   weIdle     = 0;
  int   doneCount  = 0;
  logic lastCrcOk  = 1'b0;
  logic lastTout   = 1'b0;
  int   writeCountT = 0;
  int   doneCountT  = 0;
  logic lastCrcOkT  = 1'b0;
  logic lastToutT   = 1'b0;

  // Observe buffer writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (sdIf.buf_we) begin
      if (int'(sdIf.buf_addr) != expAddr) addrErr++;
      if (sdIf.buf_data != expByte[sdIf.buf_addr]) dataErr++;
      if (!sdIf.busy) weIdle++;
      writeCount++;
      expAddr++;
    end else if (!sdIf.busy) begin
      expAddr = 0;
    end
    if (sdIf.done) begin
      doneCount++;
      lastCrcOk = sdIf.crc_ok;
      lastTout  = sdIf.timeout;
    end
    if (toIf.buf_we) writeCountT++;
    if (toIf.done) begin
      doneCountT++;
      lastCrcOkT = toIf.crc_ok;
      lastToutT  = toIf.timeout;
    end
  end

  // Guard against a hung run
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One DAT strobe, called and returning on a falling edge
  task automatic applyStimulus(input logic [3:0] nib);
    sdIf.dat_stb = 1'b1;
    sdIf.dat_in  = nib;
    @(negedge clk);
    sdIf.dat_stb = 1'b0;
    repeat (gapCycles) @(negedge clk);
  endtask

  task automatic pulseStart();
    sdIf.start = 1'b1;
    @(negedge clk);
    sdIf.start = 1'b0;
    @(negedge clk);
  endtask

  // Reference CRC16-CCITT of one DAT line over the whole expected block
  function automatic logic [15:0] crcModel(input int line);
    logic [15:0] c;
    logic [7:0]  b8;
    logic        bit_v;
    logic        fb;
    c = 16'h0000;
    for (int k = 0; k < 512; k++) begin
      b8 = expByte[k];
      for (int h = 0; h < 2; h++) begin
        bit_v = (h == 0) ? b8[4 + line] : b8[line];
        fb    = c[15] ^ bit_v;
        c     = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic sendPreamble(input int kind);
    if (kind == 0) begin
      repeat (3) applyStimulus(4'b1111);
    end else begin
      applyStimulus(4'b0101);
    end
    applyStimulus(4'b0000);
  endtask

  task automatic sendData(input int nBytes);
    for (int k = 0; k < nBytes; k++) begin
      applyStimulus(expByte[k][7:4]);
      applyStimulus(expByte[k][3:0]);
    end
  endtask

  task automatic sendTrailer(input logic [15:0] flip2, input logic [3:0] endNib);
    logic [15:0] c [4];
    for (int i = 0; i < 4; i++) c[i] = crcModel(i);
    c[2] = c[2] ^ flip2;
    for (int b = 15; b >= 0; b--) begin
      applyStimulus({c[3][b], c[2][b], c[1][b], c[0][b]});
    end
    applyStimulus(endNib);
  endtask

  // Full block from start to done, then result checks
  task automatic runBlock(input string tag, input int preKind,
                          input logic [15:0] flip2, input logic [3:0] endNib,
                          input logic expOk);
    int w0, d0, a0, e0;
    w0 = writeCount;
    d0 = doneCount;
    a0 = addrErr;
    e0 = dataErr;
    pulseStart();
    checkOutput({tag, "_busy"}, 32'(sdIf.busy), 32'd1);
    checkOutput({tag, "_crcClr"}, 32'(sdIf.crc_ok), 32'd0);
    sendPreamble(preKind);
    sendData(512);
    sendTrailer(flip2, endNib);
    for (int i = 0; i < 20 && doneCount == d0; i++) @(negedge clk);
    checkOutput({tag, "_done"}, 32'(doneCount - d0), 32'd1);
    checkOutput({tag, "_writes"}, 32'(writeCount - w0), 32'd512);
    checkOutput({tag, "_addrErr"}, 32'(addrErr - a0), 32'd0);
    checkOutput({tag, "_dataErr"}, 32'(dataErr - e0), 32'd0);
    checkOutput({tag, "_crcOk"}, 32'(lastCrcOk), 32'(expOk));
    checkOutput({tag, "_tout"}, 32'(lastTout), 32'd0);
    checkOutput({tag, "_busyLow"}, 32'(sdIf.busy), 32'd0);
    checkOutput({tag, "_lastAddr"}, 32'(sdIf.buf_addr), 32'd511);
    repeat (5) @(negedge clk);
    checkOutput({tag, "_onePulse"}, 32'(doneCount - d0), 32'd1);
    checkOutput({tag, "_crcHeld"}, 32'(sdIf.crc_ok), 32'(expOk));
  endtask

  initial begin
    int w0, d0, dT0, wT0;
    reset        = 1'b1;
    sdIf.start   = 1'b0;
    sdIf.dat_stb = 1'b0;
    sdIf.dat_in  = 4'b0000;
    repeat (3) @(negedge clk);

    checkOutput("rst_busy", 32'(sdIf.busy), 32'd0);
    checkOutput("rst_done", 32'(sdIf.done), 32'd0);
    checkOutput("rst_we", 32'(sdIf.buf_we), 32'd0);
    checkOutput("rst_crcOk", 32'(sdIf.crc_ok), 32'd0);
    checkOutput("rst_tout", 32'(sdIf.timeout), 32'd0);
    checkOutput("rst_addr", 32'(sdIf.buf_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Strobes while idle must do nothing
    repeat (4) applyStimulus(4'b0000);
    checkOutput("idle_busy", 32'(sdIf.busy), 32'd0);
    checkOutput("idle_we", 32'(writeCount), 32'd0);

    for (int k = 0; k < 512; k++) expByte[k] = 8'h00;
    runBlock("zero", 0, 16'h0000, 4'b1111, 1'b1);

    for (int k = 0; k < 512; k++) expByte[k] = 8'(k);
    gapCycles = 0;
    runBlock("incr", 0, 16'h0000, 4'b1111, 1'b1);
    gapCycles = 1;
    runBlock("crcFlip", 0, 16'h0080, 4'b1111, 1'b0);
    runBlock("badEnd", 0, 16'h0000, 4'b1110, 1'b0);
    runBlock("partial", 1, 16'h0000, 4'b1111, 1'b1);

    // Timeout on the TIMEOUT=8 instance: seven idle strobes are not enough
    dT0 = doneCountT;
    wT0 = writeCountT;
    pulseStart();
    repeat (7) applyStimulus(4'b1111);
    checkOutput("to_noEarlyDone", 32'(doneCountT - dT0), 32'd0);
    checkOutput("to_busyBefore", 32'(toIf.busy), 32'd1);
    applyStimulus(4'b1111);
    for (int i = 0; i < 20 && doneCountT == dT0; i++) @(negedge clk);
    checkOutput("to_done", 32'(doneCountT - dT0), 32'd1);
    checkOutput("to_flag", 32'(lastToutT), 32'd1);
    checkOutput("to_crcOk", 32'(lastCrcOkT), 32'd0);
    checkOutput("to_busyLow", 32'(toIf.busy), 32'd0);
    checkOutput("to_noWrites", 32'(writeCountT - wT0), 32'd0);
    checkOutput("to_mainStillWait", 32'(sdIf.busy), 32'd1);
    checkOutput("to_mainNoTout", 32'(sdIf.timeout), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("to_rstFlag", 32'(toIf.timeout), 32'd0);

    // Reset after 100 bytes of a block
    w0 = writeCount;
    d0 = doneCount;
    pulseStart();
    sendPreamble(0);
    sendData(100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midRst_writes", 32'(writeCount - w0), 32'd100);
    checkOutput("midRst_busy", 32'(sdIf.busy), 32'd0);
    checkOutput("midRst_we", 32'(sdIf.buf_we), 32'd0);
    checkOutput("midRst_addr", 32'(sdIf.buf_addr), 32'd0);
    repeat (10) applyStimulus(4'b0011);
    checkOutput("midRst_noDone", 32'(doneCount - d0), 32'd0);
    checkOutput("midRst_noMoreWrites", 32'(writeCount - w0), 32'd100);

    runBlock("afterRst", 0, 16'h0000, 4'b1111, 1'b1);
    checkOutput("weOutsideBusy", 32'(weIdle), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
